// File: rtl/mcc_pkg.sv
// Shared constants, state encoding and mux_sel helper for the MCC crossbar sequencer.
package mcc_pkg;

    localparam int XBAR_SIZE     = 32;
    localparam int XBAR_SIZE_BIN = 5;
    localparam int DATA_WIDTH    = 8;
    localparam int MUX_SEL_W     = XBAR_SIZE * XBAR_SIZE_BIN;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_B   = 3'd2,
        PROG     = 3'd3,
        PROG_GAP = 3'd4,
        SENSE    = 3'd5,
        EVAL     = 3'd6,
        DONE     = 3'd7
    } seq_state_e;

    // Row select for one column; the adder's natural truncation is the modulo wrap.
    function automatic logic [XBAR_SIZE_BIN-1:0] rot_field(
        input logic [XBAR_SIZE_BIN-1:0] col,
        input logic [XBAR_SIZE_BIN-1:0] diag
    );
        rot_field = col + diag;
    endfunction

endpackage

// File: rtl/mcc_mux_rotator.sv
// Combinational diagonal -> per-column mux_sel pattern generator.
module mcc_mux_rotator
    import mcc_pkg::*;
(
    input  logic [XBAR_SIZE_BIN-1:0] diag,
    output logic [MUX_SEL_W-1:0]     mux_sel
);

    // Each column field selects row (column + diag) mod XBAR_SIZE.
    always_comb begin
        mux_sel = '0;
        for (int j = 0; j < XBAR_SIZE; j++) begin
            mux_sel[j*XBAR_SIZE_BIN +: XBAR_SIZE_BIN] = rot_field(XBAR_SIZE_BIN'(j), diag);
        end
    end

endmodule

// File: rtl/mcc_xbar_sequencer.sv
// Program/evaluate control FSM for one memristor crossbar.
// Optional MCC_SEQ_PERF_CNT_EN adds the perf_cycles busy-cycle counter.
module mcc_xbar_sequencer
    import mcc_pkg::*;
#(
    parameter int PROG_ITERS    = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int ADC_TIMEOUT   = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout_err,
    output logic                            b_rd_en,
    output logic [2*XBAR_SIZE_BIN-1:0]      b_rd_addr,
    input  logic [DATA_WIDTH-1:0]           b_rd_data,
    input  logic                            b_rd_valid,
    output logic                            dac_wr_en,
    output logic [XBAR_SIZE_BIN-1:0]        dac_wr_idx,
    output logic [DATA_WIDTH-1:0]           dac_wr_data,
    output logic                            dac_en,
    output logic                            prog_pulse,
    output logic [MUX_SEL_W-1:0]            mux_sel,
    output logic                            adc_start,
    input  logic [DATA_WIDTH*XBAR_SIZE-1:0] adc_in,
    input  logic                            adc_valid_in,
    output logic [XBAR_SIZE*DATA_WIDTH-1:0] y_values_out,
    output logic                            y_values_valid
`ifdef MCC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_cycles
`endif
);

    localparam int ITER_W  = $clog2(PROG_ITERS + 1);
    localparam int TMR_MAX = (ADC_TIMEOUT > SETTLE_CYCLES) ? ADC_TIMEOUT : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int YW      = XBAR_SIZE * DATA_WIDTH;

    seq_state_e                   state_q, state_d;
    logic [XBAR_SIZE_BIN-1:0]     diag_q, diag_d;
    logic [XBAR_SIZE_BIN-1:0]     offset_q, offset_d;
    logic [ITER_W-1:0]            iter_q, iter_d;
    logic [TMR_W-1:0]             timer_q, timer_d;
    logic                         timeout_err_q, timeout_err_d;
    logic [YW-1:0]                y_q, y_d;
    logic                         y_valid_q, y_valid_d;
    logic                         adc_start_q, adc_start_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         b_rd_en_q, b_rd_en_d;
    logic [2*XBAR_SIZE_BIN-1:0]   b_rd_addr_q, b_rd_addr_d;
    logic                         dac_en_q, dac_en_d;
    logic                         prog_pulse_q, prog_pulse_d;
    logic [MUX_SEL_W-1:0]         mux_sel_q, mux_sel_d;
    logic [MUX_SEL_W-1:0]         rot_mux_s;
    logic                         dac_wr_en_s;

    mcc_mux_rotator u_rot (
        .diag    (diag_d),
        .mux_sel (rot_mux_s)
    );

    // Next-state, counters and result capture.
    always_comb begin
        state_d       = state_q;
        diag_d        = diag_q;
        offset_d      = offset_q;
        iter_d        = iter_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        y_d           = y_q;
        y_valid_d     = 1'b0;
        adc_start_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = FETCH;
                    diag_d        = '0;
                    offset_d      = '0;
                    iter_d        = '0;
                    timer_d       = '0;
                    timeout_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = WAIT_B;
            end
            WAIT_B: begin
                if (b_rd_valid) begin
                    if (offset_q == XBAR_SIZE_BIN'(XBAR_SIZE - 1)) begin
                        offset_d = '0;
                        iter_d   = '0;
                        state_d  = PROG;
                    end else begin
                        offset_d = offset_q + XBAR_SIZE_BIN'(1);
                        state_d  = FETCH;
                    end
                end else begin
                    state_d = WAIT_B;
                end
            end
            PROG: begin
                iter_d  = iter_q + ITER_W'(1);
                state_d = PROG_GAP;
            end
            PROG_GAP: begin
                if (iter_q == ITER_W'(PROG_ITERS)) begin
                    iter_d = '0;
                    if (diag_q == XBAR_SIZE_BIN'(XBAR_SIZE - 1)) begin
                        timer_d = '0;
                        state_d = SENSE;
                    end else begin
                        diag_d  = diag_q + XBAR_SIZE_BIN'(1);
                        state_d = FETCH;
                    end
                end else begin
                    state_d = PROG;
                end
            end
            SENSE: begin
                if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    timer_d     = '0;
                    adc_start_d = 1'b1;
                    state_d     = EVAL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            EVAL: begin
                // Valid data takes priority over an expiry in the same cycle.
                if (adc_valid_in) begin
                    y_d       = adc_in;
                    y_valid_d = 1'b1;
                    state_d   = DONE;
                end else if (timer_q == TMR_W'(ADC_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every control output is a flop.
    always_comb begin
        busy_d       = (state_d != IDLE);
        done_d       = (state_q == DONE);
        b_rd_en_d    = (state_d == FETCH);
        prog_pulse_d = (state_d == PROG);
        dac_en_d     = (state_d == SENSE) || (state_d == EVAL);
        if (state_d == FETCH) begin
            b_rd_addr_d = {diag_d, offset_d};
        end else begin
            b_rd_addr_d = b_rd_addr_q;
        end
        case (state_d)
            FETCH, WAIT_B, PROG, PROG_GAP: mux_sel_d = rot_mux_s;
            default:                       mux_sel_d = '0;
        endcase
    end

    // The DAC register write must land in the same cycle as b_rd_valid.
    always_comb begin
        dac_wr_en_s = (state_q == WAIT_B) && b_rd_valid;
        if (dac_wr_en_s) begin
            dac_wr_idx  = offset_q;
            dac_wr_data = b_rd_data;
        end else begin
            dac_wr_idx  = '0;
            dac_wr_data = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            diag_q        <= '0;
            offset_q      <= '0;
            iter_q        <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            y_q           <= '0;
            y_valid_q     <= 1'b0;
            adc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            b_rd_en_q     <= 1'b0;
            b_rd_addr_q   <= '0;
            dac_en_q      <= 1'b0;
            prog_pulse_q  <= 1'b0;
            mux_sel_q     <= '0;
        end else begin
            state_q       <= state_d;
            diag_q        <= diag_d;
            offset_q      <= offset_d;
            iter_q        <= iter_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            y_q           <= y_d;
            y_valid_q     <= y_valid_d;
            adc_start_q   <= adc_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            b_rd_en_q     <= b_rd_en_d;
            b_rd_addr_q   <= b_rd_addr_d;
            dac_en_q      <= dac_en_d;
            prog_pulse_q  <= prog_pulse_d;
            mux_sel_q     <= mux_sel_d;
        end
    end

`ifdef MCC_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: cleared by an accepted start, frozen in DONE, saturating.
    always_comb begin
        if ((state_q == IDLE) && start) begin
            perf_d = '0;
        end else if ((state_q != IDLE) && (state_q != DONE) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Perf counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout_err    = timeout_err_q;
    assign b_rd_en        = b_rd_en_q;
    assign b_rd_addr      = b_rd_addr_q;
    assign dac_wr_en      = dac_wr_en_s;
    assign dac_en         = dac_en_q;
    assign prog_pulse     = prog_pulse_q;
    assign mux_sel        = mux_sel_q;
    assign adc_start      = adc_start_q;
    assign y_values_out   = y_q;
    assign y_values_valid = y_valid_q;

endmodule

// File: tb/tb_mcc_xbar_sequencer.sv
// Self-checking bench for mcc_xbar_sequencer with behavioural memory/ADC responders.
module tb_mcc_xbar_sequencer;

    localparam int N      = 32;
    localparam int ITERS  = 5;
    localparam int SETTLE = 4;

    logic         clk = 1'b0;
    logic         rst, start;
    logic         busy, done, timeout_err, b_rd_en, b_rd_valid, dac_wr_en, dac_en;
    logic         prog_pulse, adc_start, adc_valid_in, y_values_valid;
    logic [9:0]   b_rd_addr;
    logic [7:0]   b_rd_data, dac_wr_data;
    logic [4:0]   dac_wr_idx;
    logic [159:0] mux_sel;
    logic [255:0] adc_in, y_values_out;
`ifdef MCC_SEQ_PERF_CNT_EN
    logic [31:0]  perf_cycles;
`endif

    mcc_xbar_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .timeout_err(timeout_err), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid), .dac_wr_en(dac_wr_en),
        .dac_wr_idx(dac_wr_idx), .dac_wr_data(dac_wr_data), .dac_en(dac_en),
        .prog_pulse(prog_pulse), .mux_sel(mux_sel), .adc_start(adc_start),
        .adc_in(adc_in), .adc_valid_in(adc_valid_in), .y_values_out(y_values_out),
        .y_values_valid(y_values_valid)
`ifdef MCC_SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [7:0]   mem [1024];
    logic [255:0] adc_val;
    int  b_lat, adc_lat, b_pend, adc_pend, lat_sum;
    bit  rand_lat, adc_resp_en;
    int  wr_cnt, wr_bad, rd_cnt, addr_bad, dup_cnt, prog_cnt, mux_bad, sense_mux_bad;
    int  yv_cnt, yv_cyc, done_cnt, done_cyc, as_cyc, den_cyc, job_start;
    logic [9:0]   first_addr;
    logic [159:0] mux31;
    bit  den_prev;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: returns mem[addr] b_lat (or random 1..4) cycles after each read.
    initial begin
        logic [9:0] paddr;
        paddr = '0; b_pend = 0; b_rd_valid = 1'b0; b_rd_data = '0;
        forever begin
            @(negedge clk);
            b_rd_valid = 1'b0;
            b_rd_data  = 8'($urandom);
            if (b_pend == 1) begin
                b_rd_valid = 1'b1;
                b_rd_data  = mem[paddr];
            end
            if (b_pend > 0) b_pend--;
            if (b_rd_en) begin
                if (b_pend != 0) dup_cnt++;
                b_pend  = rand_lat ? int'($urandom_range(4, 1)) : b_lat;
                lat_sum += b_pend;
                paddr   = b_rd_addr;
            end
        end
    end

    // ADC responder: answers adc_lat cycles after adc_start (0 = same cycle).
    initial begin
        adc_pend = 0; adc_valid_in = 1'b0; adc_in = '0;
        forever begin
            @(negedge clk);
            adc_valid_in = 1'b0;
            adc_in       = {8{$urandom}};
            if (adc_pend == 1) begin
                adc_valid_in = 1'b1;
                adc_in       = adc_val;
            end
            if (adc_pend > 0) adc_pend--;
            if (adc_start && adc_resp_en) begin
                if (adc_lat == 0) begin
                    adc_valid_in = 1'b1;
                    adc_in       = adc_val;
                end else begin
                    adc_pend = adc_lat;
                end
            end
        end
    end

    // Passive monitor: reference order is write k -> idx k%32, data mem[k]; pulse p -> diag p/ITERS.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (dac_wr_en) begin
                if (dac_wr_idx !== 5'(wr_cnt % N) || dac_wr_data !== mem[wr_cnt % 1024]) wr_bad++;
                wr_cnt++;
            end
            if (b_rd_en) begin
                if (rd_cnt == 0) first_addr = b_rd_addr;
                if (b_rd_addr !== 10'(rd_cnt)) addr_bad++;
                rd_cnt++;
            end
            if (prog_pulse) begin
                for (int j = 0; j < N; j++)
                    if (mux_sel[j*5 +: 5] !== 5'((j + prog_cnt / ITERS) % N)) mux_bad++;
                if (prog_cnt / ITERS == N - 1) mux31 = mux_sel;
                prog_cnt++;
            end
            if (dac_en && mux_sel !== '0) sense_mux_bad++;
            if (dac_en && !den_prev) den_cyc = cyc;
            den_prev = dac_en;
            if (adc_start) as_cyc = cyc;
            if (y_values_valid) begin yv_cnt++; yv_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic start_job();
        @(posedge clk); #1;
        wr_cnt = 0; wr_bad = 0; rd_cnt = 0; addr_bad = 0; dup_cnt = 0; prog_cnt = 0;
        mux_bad = 0; sense_mux_bad = 0; yv_cnt = 0; done_cnt = 0; lat_sum = 0;
        yv_cyc = -1; done_cyc = -1; as_cyc = -1; den_cyc = -1; first_addr = '1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        job_start = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 12000) begin @(posedge clk); n++; end
        repeat (4) @(posedge clk);
        #1;
        chk(tag, done_cnt, 1);
    endtask

    // Full program+evaluate data-path checks against the reference order and cycle model.
    task automatic chk_job(input string tag);
        chk({tag, "_wr_cnt"}, wr_cnt, 1024);
        chk({tag, "_wr_bad"}, wr_bad, 0);
        chk({tag, "_rd_addr_bad"}, addr_bad, 0);
        chk({tag, "_dup_rd"}, dup_cnt, 0);
        chk({tag, "_prog_cnt"}, prog_cnt, N * ITERS);
        chk({tag, "_mux_bad"}, mux_bad, 0);
        chk({tag, "_sense_mux"}, sense_mux_bad, 0);
        chk({tag, "_settle"}, as_cyc - den_cyc, SETTLE);
    endtask

    logic [4:0] f0, f1;
    bit reached;

    initial begin
        rst = 1'b1; start = 1'b0; adc_resp_en = 1'b1; adc_lat = 3; b_lat = 1; rand_lat = 1'b0;
        adc_val = {32{8'hA5}};
        for (int k = 0; k < 1024; k++) mem[k] = 8'(k);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, timeout_err, b_rd_en, b_rd_addr, dac_wr_en, dac_wr_idx,
            dac_wr_data, dac_en, prog_pulse, mux_sel, adc_start, y_values_out, y_values_valid}, 0);
        rst = 1'b0;

        // Basic job.
        start_job();
        chk("busy_after_start", busy, 1);
        wait_done("basic_done");
        chk_job("basic");
        f0 = mux31[4:0];
        f1 = mux31[9:5];
        chk("wrap_col0", f0, 31);
        chk("wrap_col1", f1, 0);
        chk("basic_y", y_values_out, {32{8'hA5}});
        chk("basic_yv_cnt", yv_cnt, 1);
        chk("basic_adc_lat", yv_cyc - as_cyc, 4);
        chk("basic_done_after_yv", done_cyc - yv_cyc, 1);
        chk("basic_cycles", done_cyc - job_start, lat_sum + 1024 + 2 * N * ITERS + SETTLE + adc_lat + 2);
        chk("basic_no_timeout", timeout_err, 0);
        chk("basic_idle", busy, 0);

        // ADC timeout.
        adc_resp_en = 1'b0;
        start_job();
        wait_done("to_done");
        chk("to_err", timeout_err, 1);
        chk("to_done_gap", done_cyc - as_cyc, 256);
        chk("to_no_yv", yv_cnt, 0);
        chk("to_y_hold", y_values_out, {32{8'hA5}});

        // Back-pressure: 7-cycle read latency; the start also clears timeout_err.
        adc_resp_en = 1'b1; adc_lat = 0; b_lat = 7;
        adc_val = {8{$urandom}};
        start_job();
        chk("start_clears_to", timeout_err, 0);
        wait_done("bp_done");
        chk_job("bp");
        chk("bp_y", y_values_out, adc_val);
        chk("bp_cycles", done_cyc - job_start, lat_sum + 1024 + 2 * N * ITERS + SETTLE + adc_lat + 2);

        // Randomized memory contents, read latencies and ADC latency.
        for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
        rand_lat = 1'b1; adc_lat = int'($urandom_range(20, 0));
        adc_val = {8{$urandom}};
        start_job();
        wait_done("rnd_done");
        chk_job("rnd");
        chk("rnd_y", y_values_out, adc_val);
        chk("rnd_yv_cnt", yv_cnt, 1);
        chk("rnd_cycles", done_cyc - job_start, lat_sum + 1024 + 2 * N * ITERS + SETTLE + adc_lat + 2);

        // Reset in the middle of PROG at diag 10.
        rand_lat = 1'b0; b_lat = 1; adc_lat = 3;
        start_job();
        reached = 1'b0;
        for (int n = 0; n < 3000 && !reached; n++) begin
            @(negedge clk);
            if (prog_pulse && b_rd_addr[9:5] == 5'd10) reached = 1'b1;
        end
        rst = 1'b1;
        #1;
        chk("reached_prog_d10", reached, 1);
        chk("midrst_outputs", {busy, done, timeout_err, b_rd_en, b_rd_addr, dac_wr_en, dac_wr_idx,
            dac_wr_data, dac_en, prog_pulse, mux_sel, adc_start, y_values_out, y_values_valid}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, 0);
        rst = 1'b0; b_pend = 0; adc_pend = 0;
        start_job();
        wait_done("restart_done");
        chk("restart_first_addr", first_addr, 0);
        chk_job("restart");

`ifdef MCC_SEQ_PERF_CNT_EN
        adc_lat = 0;
        start_job();
        wait_done("perf_done");
        chk("perf_value", perf_cycles, lat_sum + 1024 + 2 * N * ITERS + SETTLE + adc_lat + 1);
        repeat (5) @(posedge clk);
        #1;
        chk("perf_stable", perf_cycles, 2373);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
